// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared width default and legal width bounds for full_adder
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MIN     = 1;
  localparam int FA_WIDTH_MAX     = 32;

endpackage

// File: rtl/full_adder_fa_cell.sv
// rtl/full_adder_fa_cell.sv - one-bit combinational full-adder cell
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder with signed overflow and one output register stage
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  if (WIDTH < FA_WIDTH_MIN || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH out of legal range");
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the top cell
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it
  assign ovf  = carry[WIDTH-1] ^ carry[WIDTH];

  // Capture the combinational result on valid input; hold data otherwise, valid tracks in_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
        ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - randomized scoreboard bench for full_adder at widths 1, 4 and 8
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // width-1 instance
  logic       a1, b1, cin1, iv1;
  logic       sum1, cout1, ovf1, sum_q1, cout_q1, ovf_q1, ov1;
  // width-4 instance
  logic [3:0] a4, b4, sum4, sum_q4;
  logic       cin4, iv4, cout4, ovf4, cout_q4, ovf_q4, ov4;
  // width-8 instance
  logic [7:0] a8, b8, sum8, sum_q8;
  logic       cin8, iv8, cout8, ovf8, cout_q8, ovf_q8, ov8;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .cout(cout1), .ovf(ovf1),
    .sum_q(sum_q1), .cout_q(cout_q1), .ovf_q(ovf_q1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .sum(sum4), .cout(cout4), .ovf(ovf4),
    .sum_q(sum_q4), .cout_q(cout_q4), .ovf_q(ovf_q4), .out_valid(ov4)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(sum8), .cout(cout8), .ovf(ovf8),
    .sum_q(sum_q8), .cout_q(cout_q8), .ovf_q(ovf_q8), .out_valid(ov8)
  );

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: arithmetic sum and signed-range overflow, returned as {ovf, cout, sum[31:0]}
  function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic c);
    longint full, half, tot, xl, yl, cl, sx, sy, s;
    logic [33:0] r;
    full = longint'(1) << w;
    half = full / 2;
    xl = x; yl = y; cl = c;
    tot = xl + yl + cl;
    sx = (xl >= half) ? xl - full : xl;
    sy = (yl >= half) ? yl - full : yl;
    s  = sx + sy + cl;
    r = '0;
    r[31:0] = 32'(tot % full);
    r[32]   = (tot >= full);
    r[33]   = (s < -half) || (s >= half);
    return r;
  endfunction

  // Issue one width-8 vector; when valid, its expected registered result joins the scoreboard
  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic v);
    logic [33:0] m;
    exp_t e;
    a8 = x; b8 = y; cin8 = c; iv8 = v;
    m = model(8, {24'b0, x}, {24'b0, y}, c);
    if (v) begin
      e.s = m[7:0]; e.c = m[32]; e.o = m[33];
      sb_q.push_back(e);
      pushes++;
    end
  endtask

  // Monitor: every presented width-8 result must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov8 === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: out_valid=1 with no outstanding vector, sum_q=%0h", sum_q8);
        end else begin
          e = sb_q.pop_front();
          pops++;
          chk("sb_sum_q", sum_q8, e.s);
          chk("sb_cout_q", cout_q8, e.c);
          chk("sb_ovf_q", ovf_q8, e.o);
        end
      end
    end
  end

  initial begin
    logic [1:0]  tt [8];
    logic [33:0] m;
    logic [7:0]  x, y;
    logic        c;

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst_n = 1'b0;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a4 = 0; b4 = 0; cin4 = 0; iv4 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;

    // Reset state before any clock edge
    #2;
    chk("rst_sum_q1", sum_q1, 0);
    chk("rst_cout_q1", cout_q1, 0);
    chk("rst_ovf_q1", ovf_q1, 0);
    chk("rst_out_valid1", ov1, 0);
    chk("rst_sum_q8", sum_q8, 0);
    chk("rst_out_valid8", ov8, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // Width-1 truth table, binary-count order, 50 time units apart
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      #1;
      chk("tt_cout_sum", {cout1, sum1}, tt[i]);
      chk("tt_ovf", ovf1, cin1 ^ tt[i][1]);
      #49;
    end
    chk("novalid_out_valid1", ov1, 0);
    chk("novalid_sum_q1", sum_q1, 0);

    // Width-1 registered path: one valid edge, then hold
    @(negedge clk);
    a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
    @(negedge clk);
    chk("reg1_sum_q", sum_q1, 1);
    chk("reg1_cout_q", cout_q1, 1);
    chk("reg1_ovf_q", ovf_q1, 0);
    chk("reg1_out_valid", ov1, 1);
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    @(negedge clk);
    chk("hold1_out_valid", ov1, 0);
    chk("hold1_sum_q", sum_q1, 1);
    chk("hold1_cout_q", cout_q1, 1);

    // Width-4 boundary cases and random combinational vectors
    a4 = 4'hF; b4 = 4'h1; cin4 = 0;
    #1;
    chk("wrap4_sum", sum4, 4'h0);
    chk("wrap4_cout", cout4, 1);
    chk("wrap4_ovf", ovf4, 0);
    a4 = 4'h7; b4 = 4'h1; cin4 = 0;
    #1;
    chk("ovf4_sum", sum4, 4'h8);
    chk("ovf4_cout", cout4, 0);
    chk("ovf4_ovf", ovf4, 1);
    for (int i = 0; i < 30; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      #1;
      m = model(4, {28'b0, a4}, {28'b0, b4}, cin4);
      chk("rnd4_sum", sum4, m[3:0]);
      chk("rnd4_cout", cout4, m[32]);
      chk("rnd4_ovf", ovf4, m[33]);
    end
    chk("idle4_out_valid", ov4, 0);
    chk("idle4_sum_q", sum_q4, 0);

    // Width-8 reset asserted mid-stream between clock edges
    @(negedge clk);
    drive8(8'hA5, 8'h3C, 1'b1, 1'b1);
    @(negedge clk);
    iv8 = 1'b0;
    #2;
    chk("pre_rst_out_valid8", ov8, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum_q8", sum_q8, 0);
    chk("midrst_cout_q8", cout_q8, 0);
    chk("midrst_ovf_q8", ovf_q8, 0);
    chk("midrst_out_valid8", ov8, 0);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    #1;
    chk("inrst_sum8", sum8, 8'h00);
    chk("inrst_cout8", cout8, 1);
    a8 = 8'h40; b8 = 8'h40; cin8 = 1'b1;
    #1;
    chk("inrst2_sum8", sum8, 8'h81);
    chk("inrst2_ovf8", ovf8, 1);
    iv8 = 1'b1;
    @(negedge clk);
    chk("inrst_no_capture", ov8, 0);
    iv8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_out_valid8", ov8, 0);

    // Width-8 back-to-back random stream
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i > 0) chk("stream_out_valid8", ov8, 1);
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      if (i == 0) begin x = 8'hFF; y = 8'h01; c = 1'b0; end
      if (i == 1) begin x = 8'h80; y = 8'h80; c = 1'b0; end
      drive8(x, y, c, 1'b1);
      #1;
      m = model(8, {24'b0, x}, {24'b0, y}, c);
      chk("stream_sum8", sum8, m[7:0]);
      chk("stream_cout8", cout8, m[32]);
      chk("stream_ovf8", ovf8, m[33]);
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    chk("end_out_valid8", ov8, 0);
    chk("end_sb_empty", sb_q.size(), 0);
    chk("end_pop_count", pops, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
